// File: rtl/wb_stream_pkg.sv
// Shared constants for the Wishbone stream writer:
// CSR map, CTRL bits, FSM encoding and cycle-type codes.
package wb_stream_pkg;

    localparam logic [9:0] CSR_BASE    = 10'd0;
    localparam logic [9:0] CSR_COUNT   = 10'd1;
    localparam logic [9:0] CSR_CTRL    = 10'd2;
    localparam logic [9:0] CSR_WRITTEN = 10'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_BUSY  = 1;
    localparam int CTRL_DONE  = 2;
    localparam int CTRL_ABORT = 3;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_BURST = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/wb_stream_fifo.sv
// Word FIFO between the stream port and the Wishbone master.
// A pop frees a slot in the same cycle, so push-while-full works with a pop.
module wb_stream_fifo
    import wb_stream_pkg::*;
#(
    parameter int depth_log2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [31:0]           din,
    output logic [31:0]           dout,
    output logic                  full,
    output logic                  empty,
    output logic [depth_log2:0]   level
);

    localparam int depth = 2 ** depth_log2;

    logic [31:0]           mem [depth];
    logic [depth_log2-1:0] wr_ptr;
    logic [depth_log2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = level[depth_log2];
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + {{depth_log2{1'b0}}, do_push}
                           - {{depth_log2{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/wb_stream_writer.sv
// Stream-to-Wishbone writer: buffers stream words and writes them
// as incrementing bursts starting at a CSR-programmed base address.
module wb_stream_writer
    import wb_stream_pkg::*;
#(
    parameter logic [3:0] csr_addr        = 4'h2,
    parameter int         fifo_depth_log2 = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [13:0] csr_a,
    input  logic        csr_we,
    input  logic [31:0] csr_di,
    output logic [31:0] csr_do,
    output logic        irq,
    input  logic [31:0] st_dat_i,
    input  logic        st_stb_i,
    output logic        st_ack_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic [2:0]  wb_cti_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i
);

    state_t state, state_d;

    logic [31:0] base, ptr, rd_data, fifo_dout;
    logic [15:0] count, len, remaining, written, accepted;
    logic        done, abort_pend, fresh;
    logic [2:0]  cti_q, cti_now;
    logic        csr_sel, csr_wr, start_wr, abort_wr, clr_done;
    logic        push, pop, flush, finish, beat_done, busy, burst;
    logic        fifo_full, fifo_empty;
    logic [fifo_depth_log2:0] level;

    assign csr_sel  = (csr_a[13:10] == csr_addr);
    assign csr_wr   = csr_sel && csr_we;
    assign start_wr = csr_wr && csr_a[9:0] == CSR_CTRL && csr_di[CTRL_START];
    assign abort_wr = csr_wr && csr_a[9:0] == CSR_CTRL && csr_di[CTRL_ABORT];
    assign clr_done = csr_wr && csr_a[9:0] == CSR_CTRL && csr_di[CTRL_DONE];

    assign busy     = (state != ST_IDLE);
    assign burst    = (state == ST_BURST);
    assign st_ack_o = busy && !fifo_full && (accepted < len);
    assign push     = st_stb_i && st_ack_o;

    wb_stream_fifo #(
        .depth_log2(fifo_depth_log2)
    ) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (st_dat_i),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    // Cycle type is decided on the first cycle of a beat, then held.
    assign cti_now = (remaining == 16'd1 ||
                      level == {{fifo_depth_log2{1'b0}}, 1'b1})
                     ? CTI_EOB : CTI_INC;

    assign wb_cyc_o = burst;
    assign wb_stb_o = burst;
    assign wb_we_o  = burst;
    assign wb_sel_o = burst ? 4'hf : 4'h0;
    assign wb_adr_o = burst ? ptr : 32'h0;
    assign wb_dat_o = burst ? fifo_dout : 32'h0;
    assign wb_cti_o = !burst ? CTI_CLASSIC : (fresh ? cti_now : cti_q);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= ST_IDLE;
        else            state <= state_d;
    end

    always_comb begin
        state_d   = state;
        pop       = 1'b0;
        flush     = 1'b0;
        finish    = 1'b0;
        beat_done = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start_wr) state_d = ST_FILL;
            end
            ST_FILL: begin
                if (abort_wr) begin
                    state_d = ST_IDLE;
                    flush   = 1'b1;
                end else if (remaining == '0) begin
                    state_d = ST_IDLE;
                    finish  = 1'b1;
                end else if (!fifo_empty) begin
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (wb_ack_i) begin
                    pop       = 1'b1;
                    beat_done = 1'b1;
                    if (abort_pend || abort_wr) begin
                        state_d = ST_IDLE;
                        flush   = 1'b1;
                    end else if (wb_cti_o == CTI_EOB) begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (remaining == '0) begin
                    state_d = ST_IDLE;
                    finish  = 1'b1;
                end else if (abort_wr) begin
                    state_d = ST_IDLE;
                    flush   = 1'b1;
                end else begin
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_data = '0;
        case (csr_a[9:0])
            CSR_BASE:    rd_data = base;
            CSR_COUNT:   rd_data = {16'h0, count};
            CSR_CTRL: begin
                rd_data[CTRL_BUSY] = busy;
                rd_data[CTRL_DONE] = done;
            end
            CSR_WRITTEN: rd_data = {16'h0, written};
            default:     rd_data = '0;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            base       <= '0;
            count      <= '0;
            ptr        <= '0;
            len        <= '0;
            remaining  <= '0;
            written    <= '0;
            accepted   <= '0;
            done       <= 1'b0;
            irq        <= 1'b0;
            abort_pend <= 1'b0;
            fresh      <= 1'b0;
            cti_q      <= CTI_CLASSIC;
            csr_do     <= '0;
        end else begin
            if (csr_wr && csr_a[9:0] == CSR_BASE)
                base <= {csr_di[31:2], 2'b00};
            if (csr_wr && csr_a[9:0] == CSR_COUNT)
                count <= csr_di[15:0];
            if (start_wr && !busy) begin
                ptr       <= base;
                remaining <= count;
                len       <= count;
                written   <= '0;
                accepted  <= '0;
            end else begin
                if (beat_done) begin
                    ptr       <= ptr + 32'd4;
                    remaining <= remaining - 16'd1;
                    written   <= written + 16'd1;
                end
                if (push) accepted <= accepted + 16'd1;
            end
            if (finish)        done <= 1'b1;
            else if (clr_done) done <= 1'b0;
            irq        <= finish;
            abort_pend <= burst && state_d == ST_BURST
                          && (abort_pend || abort_wr);
            fresh      <= state_d == ST_BURST && (!burst || beat_done);
            cti_q      <= wb_cti_o;
            csr_do     <= csr_sel ? rd_data : 32'h0;
        end
    end

endmodule

// File: tb/tb_wb_stream_writer.sv
// Randomized bench for wb_stream_writer with a queue-based reference
// model of the expected Wishbone write sequence.
module tb_wb_stream_writer;

    localparam int         DEPTH = 16;
    localparam logic [3:0] PAGE  = 4'h2;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di;
    logic [31:0] csr_do;
    logic        irq;
    logic [31:0] st_dat_i;
    logic        st_stb_i;
    logic        st_ack_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [2:0]  wb_cti_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;

    wb_stream_writer dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .csr_a     (csr_a),
        .csr_we    (csr_we),
        .csr_di    (csr_di),
        .csr_do    (csr_do),
        .irq       (irq),
        .st_dat_i  (st_dat_i),
        .st_stb_i  (st_stb_i),
        .st_ack_o  (st_ack_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_o  (wb_sel_o),
        .wb_cti_o  (wb_cti_o),
        .wb_we_o   (wb_we_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_ack_i  (wb_ack_i)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    logic [31:0] src_q[$];
    logic [31:0] pushed_q[$];
    logic [31:0] xb;
    logic [31:0] snap_adr, snap_dat;
    logic [2:0]  snap_cti;
    logic [31:0] rd;
    int xn, acked, sent, occ, max_occ, irq_cnt, cyc_rise;
    int wait_cnt, ack_min, ack_max, hold_first, rate, period, cool;
    bit xfer_on, beat_open, eob_acked, prev_irq, prev_cyc, cyc_seen;

    // One clock of slave, source and model bookkeeping, at the falling edge.
    task automatic step();
        @(negedge sys_clk);
        if (occ == DEPTH) check("full_stall", st_ack_o, 0);
        if (occ > max_occ) max_occ = occ;
        if (xfer_on && sent == xn) check("len_stall", st_ack_o, 0);
        if (eob_acked) check("gap_cycle", wb_cyc_o, 0);
        eob_acked = 0;
        if (irq) begin
            irq_cnt++;
            check("irq_width", prev_irq, 0);
        end
        prev_irq = irq;
        if (wb_cyc_o) cyc_seen = 1;
        if (wb_cyc_o && !prev_cyc) cyc_rise++;
        prev_cyc = wb_cyc_o;

        wb_ack_i = 1'b0;
        if (wb_stb_o) begin
            if (!beat_open) begin
                beat_open = 1;
                snap_adr = wb_adr_o;
                snap_dat = wb_dat_o;
                snap_cti = wb_cti_o;
                check("beat_adr", wb_adr_o, xb + 32'(acked * 4));
                check("beat_dat", wb_dat_o,
                      pushed_q.size() > 0 ? pushed_q[0] : 32'hDEAD_BEEF);
                check("beat_cti", {29'h0, wb_cti_o},
                      (xn - acked == 1 || occ == 1) ? 32'h7 : 32'h2);
                check("beat_sel_we", {27'h0, wb_sel_o, wb_we_o}, 32'h1f);
                if (acked == 0 && hold_first > 0) wait_cnt = hold_first;
                else wait_cnt = int'($urandom_range(ack_max, ack_min));
            end else begin
                check("hold_adr", wb_adr_o, snap_adr);
                check("hold_dat", wb_dat_o, snap_dat);
                check("hold_cti", {29'h0, wb_cti_o}, {29'h0, snap_cti});
            end
            if (wait_cnt == 0) begin
                wb_ack_i = 1'b1;
                beat_open = 0;
                acked++;
                occ--;
                if (pushed_q.size() > 0) void'(pushed_q.pop_front());
                eob_acked = (snap_cti == 3'b111);
            end else begin
                wait_cnt--;
            end
        end else begin
            beat_open = 0;
        end

        st_stb_i = 1'b0;
        if (cool > 0) begin
            cool--;
        end else if (src_q.size() > 0 && int'($urandom_range(99)) < rate) begin
            st_stb_i = 1'b1;
            st_dat_i = src_q[0];
            if (st_ack_o) begin
                pushed_q.push_back(src_q.pop_front());
                sent++;
                occ++;
                cool = period;
            end
        end
    endtask

    task automatic csr_write(logic [9:0] off, logic [31:0] d);
        csr_a  = {PAGE, off};
        csr_di = d;
        csr_we = 1'b1;
        step();
        csr_we = 1'b0;
    endtask

    task automatic csr_read_raw(logic [13:0] a, output logic [31:0] d);
        csr_a  = a;
        csr_we = 1'b0;
        step();
        d = csr_do;
    endtask

    task automatic csr_read(logic [9:0] off, output logic [31:0] d);
        csr_read_raw({PAGE, off}, d);
    endtask

    task automatic fill_random(int n);
        src_q.delete();
        for (int i = 0; i < n; i++) src_q.push_back($urandom);
    endtask

    task automatic start_xfer(logic [31:0] base, int n);
        xb = {base[31:2], 2'b00};
        xn = n;
        acked = 0;
        sent = 0;
        max_occ = 0;
        cyc_seen = 0;
        cyc_rise = 0;
        xfer_on = 1;
        csr_write(10'd0, base);
        csr_write(10'd1, 32'(n));
        csr_write(10'd2, 32'h1);
    endtask

    task automatic wait_done(string tag, int budget);
        int i0 = irq_cnt;
        int k = 0;
        while (irq_cnt == i0 && k < budget) begin
            step();
            k++;
        end
        check({tag, "_irq"}, irq_cnt - i0, 1);
        step();
        step();
        check({tag, "_irq_once"}, irq_cnt - i0, 1);
        check({tag, "_acked"}, acked, xn);
        check({tag, "_drained"}, pushed_q.size(), 0);
        xfer_on = 0;
        csr_read(10'd3, rd);
        check({tag, "_written"}, rd, xn);
        csr_read(10'd2, rd);
        check({tag, "_ctrl"}, rd, 32'h4);
    endtask

    initial begin
        int i0;
        int k;
        csr_a = '0; csr_we = 0; csr_di = '0;
        st_dat_i = '0; st_stb_i = 0; wb_ack_i = 0;
        occ = 0; irq_cnt = 0; xn = 0; acked = 0; sent = 0; xb = '0;
        rate = 100; period = 0; cool = 0;
        ack_min = 0; ack_max = 0; hold_first = 0; wait_cnt = 0;
        xfer_on = 0; beat_open = 0; eob_acked = 0;
        prev_irq = 0; prev_cyc = 0; cyc_seen = 0; cyc_rise = 0;

        sys_rst_n = 1'b1;
        #1 sys_rst_n = 1'b0;
        #1;
        check("rst_bus", {wb_cyc_o, wb_stb_o, wb_we_o, st_ack_o, irq}, 0);
        check("rst_adr", wb_adr_o, 0);
        check("rst_dat", wb_dat_o, 0);
        check("rst_sel_cti", {25'h0, wb_sel_o, wb_cti_o}, 0);
        check("rst_csr_do", csr_do, 0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;

        for (int o = 0; o < 4; o++) begin
            csr_read(10'(o), rd);
            check("rst_csr", rd, 0);
        end

        csr_write(10'd0, 32'h1234_567B);
        csr_read(10'd0, rd);
        check("base_align", rd, 32'h1234_5678);
        csr_read_raw({4'h3, 10'd0}, rd);
        check("page_other", rd, 0);
        csr_read(10'd7, rd);
        check("unmapped", rd, 0);

        // Basic three-word burst
        src_q.delete();
        src_q.push_back(32'hA);
        src_q.push_back(32'hB);
        src_q.push_back(32'hC);
        start_xfer(32'h4000_0100, 3);
        wait_done("basic", 200);
        check("basic_cycles", cyc_rise, 1);

        // Slow stream: one word every five cycles
        period = 4;
        fill_random(2);
        start_xfer(32'h0000_2000, 2);
        wait_done("slow", 200);
        check("slow_cycles", cyc_rise, 2);
        period = 0;

        // Slave withholds the first ack long enough to fill the FIFO
        hold_first = 30;
        fill_random(20);
        start_xfer(32'h8000_0040, 20);
        wait_done("bp", 400);
        check("bp_fill", max_occ, DEPTH);
        hold_first = 0;

        fill_random(0);
        start_xfer(32'h0000_0100, 0);
        wait_done("zero", 20);
        check("zero_nocyc", cyc_seen, 0);

        // Address wraps past 2^32
        ack_max = 2;
        rate = 60;
        fill_random(4);
        start_xfer(32'hFFFF_FFF8, 4);
        wait_done("wrap", 300);

        for (int t = 0; t < 5; t++) begin
            ack_max = int'($urandom_range(3));
            rate = int'($urandom_range(100, 30));
            k = int'($urandom_range(24, 1));
            fill_random(k);
            start_xfer($urandom, k);
            if (t == 2) begin
                repeat (5) step();
                csr_write(10'd2, 32'h1);
            end
            wait_done("rand", 800);
        end

        // Abort while the slave delays the ack by three cycles
        ack_min = 3;
        ack_max = 3;
        rate = 100;
        csr_write(10'd2, 32'h4);
        csr_read(10'd2, rd);
        check("done_clear", rd, 0);
        fill_random(8);
        i0 = irq_cnt;
        start_xfer(32'h0000_3000, 8);
        k = 0;
        while (!beat_open && k < 50) begin
            step();
            k++;
        end
        check("abort_beat_seen", beat_open, 1);
        csr_write(10'd2, 32'h8);
        repeat (8) step();
        check("abort_beats", acked, 1);
        check("abort_noirq", irq_cnt - i0, 0);
        csr_read(10'd2, rd);
        check("abort_ctrl", rd, 0);
        csr_read(10'd3, rd);
        check("abort_written", rd, 1);
        xfer_on = 0;
        src_q.delete();
        pushed_q.delete();
        occ = 0;

        ack_min = 0;
        ack_max = 0;
        src_q.push_back(32'h5A5A_0001);
        start_xfer(32'h0000_0200, 1);
        wait_done("post_abort", 100);

        // Reset in the middle of a held beat
        ack_min = 60;
        ack_max = 60;
        fill_random(4);
        start_xfer(32'h0000_4000, 4);
        k = 0;
        while (!beat_open && k < 50) begin
            step();
            k++;
        end
        check("rst_beat_seen", beat_open, 1);
        #2 sys_rst_n = 1'b0;
        #1;
        check("rst_mid_cyc", {wb_cyc_o, wb_stb_o}, 0);
        check("rst_mid_ack", st_ack_o, 0);
        check("rst_mid_do", csr_do, 0);
        wb_ack_i = 1'b0;
        st_stb_i = 1'b0;
        beat_open = 0;
        xfer_on = 0;
        src_q.delete();
        pushed_q.delete();
        occ = 0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int o = 0; o < 4; o++) begin
            csr_read(10'(o), rd);
            check("rst_mid_csr", rd, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
